// File: rtl/alu_exec_seq.sv
// RV32I/M execute stage: decodes aluOp/funct7/funct3, runs single-cycle ALU ops
// directly and mul/div on an iterative shift-add / restoring-division datapath.
module alu_exec_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int ENABLE_M   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            aluOp,
   input  logic [6:0]            funct7,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  illegal,
   output logic                  busy
);

   localparam int W   = DATA_WIDTH;
   localparam int SHW = $clog2(W);
   localparam int CW  = $clog2(W);
   localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
      OP_PASS, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   state_t          state_q;
   logic            out_valid_q, illegal_q, busy_q;
   logic [W-1:0]    result_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    hi_q, lo_q, opnd_q;
   logic            neg_q, neg_r_q, is_mul_q, sel_q;

   op_t             op_d;
   logic            ill_d, fast_d, is_mul_d, sel_d;
   logic [W-1:0]    fast_res_d, mag_a_d, mag_b_d, fix_res_d;
   logic            a_neg_d, b_neg_d;
   logic [SHW-1:0]  shamt;
   logic            b_zero, ovf;
   logic            accept;

   logic [W:0]      mul_sum;
   logic [W:0]      div_sh;
   logic            div_ge;
   logic [W-1:0]    div_diff;
   logic [2*W-1:0]  prod_n;
   logic [W-1:0]    q_n, r_n;

   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign illegal   = illegal_q;
   assign busy      = busy_q;

   always_comb begin
      op_d  = OP_ADD;
      ill_d = 1'b0;
      case (aluOp)
         2'b11: begin
            case (funct3)
               3'd0: op_d = OP_ADD;
               3'd1: if (funct7 == 7'h00) op_d = OP_SLL; else ill_d = 1'b1;
               3'd2: op_d = OP_SLT;
               3'd3: op_d = OP_SLTU;
               3'd4: op_d = OP_XOR;
               3'd5: begin
                  if (funct7 == 7'h00)      op_d = OP_SRL;
                  else if (funct7 == 7'h20) op_d = OP_SRA;
                  else                      ill_d = 1'b1;
               end
               3'd6: op_d = OP_OR;
               default: op_d = OP_AND;
            endcase
         end
         2'b10: begin
            if (funct7 == 7'h00) begin
               case (funct3)
                  3'd0: op_d = OP_ADD;
                  3'd1: op_d = OP_SLL;
                  3'd2: op_d = OP_SLT;
                  3'd3: op_d = OP_SLTU;
                  3'd4: op_d = OP_XOR;
                  3'd5: op_d = OP_SRL;
                  3'd6: op_d = OP_OR;
                  default: op_d = OP_AND;
               endcase
            end else if (funct7 == 7'h20) begin
               if (funct3 == 3'd0)      op_d = OP_SUB;
               else if (funct3 == 3'd5) op_d = OP_SRA;
               else                     ill_d = 1'b1;
            end else if (funct7 == 7'h01 && ENABLE_M != 0) begin
               case (funct3)
                  3'd0: op_d = OP_MUL;
                  3'd1: op_d = OP_MULH;
                  3'd2: op_d = OP_MULHSU;
                  3'd3: op_d = OP_MULHU;
                  3'd4: op_d = OP_DIV;
                  3'd5: op_d = OP_DIVU;
                  3'd6: op_d = OP_REM;
                  default: op_d = OP_REMU;
               endcase
            end else begin
               ill_d = 1'b1;
            end
         end
         2'b01:   op_d = OP_PASS;
         default: op_d = OP_ADD;
      endcase
   end

   // Single-cycle results, including the div-by-zero and signed-overflow shortcuts.
   always_comb begin
      shamt      = op_b[SHW-1:0];
      b_zero     = (op_b == '0);
      ovf        = (op_a == MIN_V) && (op_b == '1);
      fast_res_d = '0;
      fast_d     = 1'b1;
      case (op_d)
         OP_ADD:  fast_res_d = op_a + op_b;
         OP_SUB:  fast_res_d = op_a - op_b;
         OP_SLL:  fast_res_d = op_a << shamt;
         OP_SLT:  fast_res_d = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU: fast_res_d = {{(W-1){1'b0}}, op_a < op_b};
         OP_XOR:  fast_res_d = op_a ^ op_b;
         OP_SRL:  fast_res_d = op_a >> shamt;
         OP_SRA:  fast_res_d = $unsigned($signed(op_a) >>> shamt);
         OP_OR:   fast_res_d = op_a | op_b;
         OP_AND:  fast_res_d = op_a & op_b;
         OP_PASS: fast_res_d = op_b;
         OP_DIV: begin
            fast_d     = b_zero | ovf;
            fast_res_d = b_zero ? '1 : MIN_V;
         end
         OP_REM: begin
            fast_d     = b_zero | ovf;
            fast_res_d = b_zero ? op_a : '0;
         end
         OP_DIVU: begin
            fast_d     = b_zero;
            fast_res_d = '1;
         end
         OP_REMU: begin
            fast_d     = b_zero;
            fast_res_d = op_a;
         end
         default: fast_d = 1'b0;
      endcase
   end

   always_comb begin
      is_mul_d = (op_d == OP_MUL) || (op_d == OP_MULH) || (op_d == OP_MULHSU) || (op_d == OP_MULHU);
      sel_d    = is_mul_d ? (op_d != OP_MUL) : ((op_d == OP_REM) || (op_d == OP_REMU));
      a_neg_d  = ((op_d == OP_MULH) || (op_d == OP_MULHSU) || (op_d == OP_DIV) || (op_d == OP_REM))
                 & op_a[W-1];
      b_neg_d  = ((op_d == OP_MULH) || (op_d == OP_DIV) || (op_d == OP_REM)) & op_b[W-1];
      mag_a_d  = a_neg_d ? -op_a : op_a;
      mag_b_d  = b_neg_d ? -op_b : op_b;
   end

   // One iteration step: hi/lo hold partial product or remainder/quotient.
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      div_sh   = {hi_q, lo_q[W-1]};
      div_ge   = (div_sh >= {1'b0, opnd_q});
      div_diff = div_sh[W-1:0] - opnd_q;
      prod_n   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      q_n      = neg_q ? -lo_q : lo_q;
      r_n      = neg_r_q ? -hi_q : hi_q;
      if (is_mul_q) fix_res_d = sel_q ? prod_n[2*W-1:W] : prod_n[W-1:0];
      else          fix_res_d = sel_q ? r_n : q_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         illegal_q   <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         neg_q       <= 1'b0;
         neg_r_q     <= 1'b0;
         is_mul_q    <= 1'b0;
         sel_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  illegal_q <= ill_d;
                  if (fast_d) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= fast_res_d;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q     <= CALC;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b1;
                     cnt_q       <= '0;
                     hi_q        <= '0;
                     lo_q        <= is_mul_d ? mag_b_d : mag_a_d;
                     opnd_q      <= is_mul_d ? mag_a_d : mag_b_d;
                     neg_q       <= a_neg_d ^ b_neg_d;
                     neg_r_q     <= a_neg_d;
                     is_mul_q    <= is_mul_d;
                     sel_q       <= sel_d;
                  end
               end else if (state_q == DONE && out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            CALC: begin
               if (is_mul_q) begin
                  hi_q <= mul_sum[W:1];
                  lo_q <= {mul_sum[0], lo_q[W-1:1]};
               end else begin
                  hi_q <= div_ge ? div_diff : div_sh[W-1:0];
                  lo_q <= {lo_q[W-2:0], div_ge};
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(W-1)) state_q <= FIX;
            end
            FIX: begin
               result_q    <= fix_res_d;
               out_valid_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed-vector bench for alu_exec_seq: table of ops plus backpressure,
// ENABLE_M=0 decode and mid-operation reset sequences.
module tb_alu_exec_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic [1:0]  aluOp;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        in_ready, out_valid, illegal, busy;
   logic [31:0] result;
   logic        nm_in_ready, nm_out_valid, nm_illegal, nm_busy;
   logic [31:0] nm_result;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   alu_exec_seq #(.DATA_WIDTH(32), .ENABLE_M(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .aluOp(aluOp), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .illegal(illegal), .busy(busy)
   );

   alu_exec_seq #(.DATA_WIDTH(32), .ENABLE_M(0)) dut_nm (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready),
      .aluOp(aluOp), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .out_valid(nm_out_valid), .out_ready(out_ready), .result(nm_result),
      .illegal(nm_illegal), .busy(nm_busy)
   );

   typedef struct {
      logic [1:0]  op;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic ill, input int lat);
      vec_t v;
      v.op = op; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
      v.res = res; v.ill = ill; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
      aluOp = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   lat;
      logic bad;
      @(negedge clk);
      drive(v.op, v.f7, v.f3, v.a, v.b);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      bad = 1'b0;
      while (!out_valid && lat < 60) begin
         if (!busy || in_ready) bad = 1'b1;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      $display("txn %0d: op=%b f7=%h f3=%0d a=%h b=%h -> result=%h illegal=%0b latency=%0d",
               idx, v.op, v.f7, v.f3, v.a, v.b, result, illegal, lat);
      chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("result[%0d]", idx), result, v.res);
      chk($sformatf("illegal[%0d]", idx), {31'b0, illegal}, {31'b0, v.ill});
      if (v.lat > 1) chk($sformatf("busy_hold[%0d]", idx), {31'b0, bad}, 32'd0);
   endtask

   initial begin
      int   lat;
      logic bad;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      aluOp = 2'b00; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;

      vecs.push_back(mk(2'b10, 7'h20, 3'd0, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1));  // SUB
      vecs.push_back(mk(2'b10, 7'h01, 3'd1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 1'b0, 34)); // MULH
      vecs.push_back(mk(2'b10, 7'h01, 3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1));  // DIVU /0
      vecs.push_back(mk(2'b10, 7'h01, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1));  // REM ovf
      vecs.push_back(mk(2'b10, 7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1));  // DIV ovf
      vecs.push_back(mk(2'b10, 7'h01, 3'd6, 32'd7,        32'd0,        32'd7,        1'b0, 1));  // REM /0
      vecs.push_back(mk(2'b10, 7'h01, 3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1));  // DIV /0
      vecs.push_back(mk(2'b11, 7'h20, 3'd5, 32'hF0000000, 32'd4,        32'hFF000000, 1'b0, 1));  // SRAI
      vecs.push_back(mk(2'b11, 7'h10, 3'd5, 32'h10,       32'h20,       32'h30,       1'b1, 1));  // bad shift
      vecs.push_back(mk(2'b11, 7'h00, 3'd1, 32'd1,        32'h23,       32'd8,        1'b0, 1));  // SLLI
      vecs.push_back(mk(2'b11, 7'h20, 3'd1, 32'd1,        32'd2,        32'd3,        1'b1, 1));  // bad SLLI
      vecs.push_back(mk(2'b11, 7'h00, 3'd6, 32'h0F,       32'hF0,       32'hFF,       1'b0, 1));  // ORI
      vecs.push_back(mk(2'b11, 7'h00, 3'd7, 32'hFF,       32'h3C,       32'h3C,       1'b0, 1));  // ANDI
      vecs.push_back(mk(2'b10, 7'h00, 3'd0, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1));  // ADD wrap
      vecs.push_back(mk(2'b10, 7'h00, 3'd2, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1));  // SLT
      vecs.push_back(mk(2'b10, 7'h00, 3'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1));  // SLTU
      vecs.push_back(mk(2'b10, 7'h00, 3'd4, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1));  // XOR
      vecs.push_back(mk(2'b10, 7'h00, 3'd5, 32'h80000000, 32'd31,       32'd1,        1'b0, 1));  // SRL
      vecs.push_back(mk(2'b01, 7'h00, 3'd0, 32'd123,      32'hABCDE000, 32'hABCDE000, 1'b0, 1));  // LUI
      vecs.push_back(mk(2'b00, 7'h00, 3'd0, 32'd3,        32'd4,        32'd7,        1'b0, 1));  // no-op ADD
      vecs.push_back(mk(2'b10, 7'h20, 3'd1, 32'd1,        32'd1,        32'd2,        1'b1, 1));  // bad R f7=20
      vecs.push_back(mk(2'b10, 7'h05, 3'd0, 32'd10,       32'd20,       32'd30,       1'b1, 1));  // bad funct7
      vecs.push_back(mk(2'b10, 7'h01, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34)); // MUL
      vecs.push_back(mk(2'b10, 7'h01, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34)); // MULHU
      vecs.push_back(mk(2'b10, 7'h01, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34)); // MULHSU
      vecs.push_back(mk(2'b10, 7'h01, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34)); // MULH -1*-1
      vecs.push_back(mk(2'b10, 7'h01, 3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 34)); // DIV -100/7
      vecs.push_back(mk(2'b10, 7'h01, 3'd6, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0, 34)); // REM -100%7
      vecs.push_back(mk(2'b10, 7'h01, 3'd5, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 1'b0, 34)); // DIVU
      vecs.push_back(mk(2'b10, 7'h01, 3'd7, 32'hFFFFFFFF, 32'd16,       32'd15,       1'b0, 34)); // REMU

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result",    result,             32'd0);
      chk("rst_illegal",   {31'b0, illegal},   32'd0);
      chk("rst_busy",      {31'b0, busy},      32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      rst = 1'b0;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // ENABLE_M=0 treats funct7=01 as illegal; the M instance computes the product
      @(negedge clk);
      drive(2'b10, 7'h01, 3'd0, 32'd6, 32'd7);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      $display("txn nm: MUL 6*7 on ENABLE_M=0 -> result=%h illegal=%0b", nm_result, nm_illegal);
      chk("nm_out_valid", {31'b0, nm_out_valid}, 32'd1);
      chk("nm_illegal",   {31'b0, nm_illegal},   32'd1);
      chk("nm_result",    nm_result,             32'd13);
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      $display("txn m: MUL 6*7 -> result=%h latency=%0d", result, lat);
      chk("m_latency", 32'(lat), 32'd34);
      chk("m_result",  result,   32'd42);

      // Backpressure: result held in DONE, then back-to-back accept
      @(negedge clk);
      out_ready = 1'b0;
      drive(2'b10, 7'h00, 3'd0, 32'd3, 32'd4);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (!out_valid || result !== 32'd7 || in_ready) bad = 1'b1;
         @(negedge clk);
      end
      $display("txn bp: ADD 3+4 held 5 cycles -> result=%h out_valid=%0b", result, out_valid);
      chk("bp_hold", {31'b0, bad}, 32'd0);
      out_ready = 1'b1;
      drive(2'b10, 7'h00, 3'd0, 32'd1, 32'd1);
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      $display("txn b2b: ADD 1+1 -> result=%h out_valid=%0b", result, out_valid);
      chk("b2b_out_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_result",    result,             32'd2);

      // Reset in the middle of a DIV
      @(negedge clk);
      drive(2'b10, 7'h01, 3'd4, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("calc_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      $display("txn rst: reset during DIV -> out_valid=%0b busy=%0b result=%h", out_valid, busy, result);
      chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_busy",      {31'b0, busy},      32'd0);
      chk("abort_result",    result,             32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      run_vec(100, mk(2'b10, 7'h01, 3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 34));
      run_vec(101, mk(2'b10, 7'h01, 3'd6, 32'd100, 32'hFFFFFFF9, 32'd2,        1'b0, 34));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Parametrised successor to the ALU control decoder.
- Decodes aluOp/funct7/funct3 itself and executes the operation on two operands.
- Base RV32I ops complete in one cycle. Optional RV32M mul/div runs on an iterative multi-cycle datapath.
- Sits between the register-read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, operand/result width (≥4, even).
- ENABLE_M, 1, 1 = decode funct7=7'h01 as M-extension; 0 = treat it as illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- aluOp  input  2  11 I-type, 10 R-type, 01 U-type, 00 no-op.
- funct7  input  7  instruction bits 31:25.
- funct3  input  3  instruction bits 14:12.
- op_a  input  DATA_WIDTH  rs1 value.
- op_b  input  DATA_WIDTH  rs2 value or immediate.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  DATA_WIDTH  operation result.
- illegal  output  1  decoded combination is not legal; qualified by out_valid.
- busy  output  1  iterative operation in progress.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (async, any state): state=IDLE; out_valid=0, result=0, illegal=0, busy=0; counter and operand registers cleared. Reset mid-CALC aborts the operation with no output.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready; operands and decode fields are captured on accept.
- Decode, aluOp=11:
  - funct3 0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND.
  - funct3 1: SLL; illegal if funct7≠0.
  - funct3 5: funct7=0 SRL, funct7=7'h20 SRA, else illegal.
- Decode, aluOp=10:
  - funct7=0: funct3 0..7 = ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7=7'h20: funct3 0 SUB, 5 SRA, else illegal.
  - funct7=7'h01 with ENABLE_M=1: funct3 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Any other funct7: illegal.
- Decode, aluOp=01: result=op_b (pass, LUI).
- Decode, aluOp=00: ADD.
- Illegal combos: result = op_a+op_b, illegal=1.
- Shift amount = op_b[$clog2(DATA_WIDTH)-1:0]. SLT/DIV/REM signed; SLTU/DIVU/REMU unsigned; all arithmetic wraps modulo 2^DATA_WIDTH.
- Single-cycle ops, div-by-zero and signed overflow: accept edge → DONE. out_valid=1 the next cycle (latency 1).
- Div by zero (op_b=0): DIV/DIVU result all-ones; REM/REMU result = op_a.
- Signed overflow (DIV/REM with op_a=MIN, op_b=-1): DIV result = MIN, REM result = 0.
- Other mul/div ops take the iterative path:
  - Accept edge → CALC, busy=1. Operand magnitudes are taken per signedness: MULH both signed, MULHSU op_a signed only.
  - CALC runs DATA_WIDTH edges: multiply = one shift-add step per edge; divide = one restoring-division step per edge.
  - Then FIX (1 edge): applies sign correction. The quotient is negated if the operand signs differ; the remainder takes the sign of op_a. Selects the low or high half of the 2·DATA_WIDTH product.
  - FIX → DONE: out_valid=1, busy=0. Latency = DATA_WIDTH+2 edges from accept.
  - in_ready=0 throughout CALC and FIX; in_valid during those states is ignored.
- DONE:
  - out_ready=0: result and illegal hold stable, out_valid stays 1.
  - out_ready=1 with no new accept: → IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept: the new request is taken that same edge (back-to-back, no bubble for single-cycle ops).
- result is registered; no combinational path from the op inputs to result.

Test Plan:
- aluOp=10, funct7=0x20, funct3=0, op_a=5, op_b=7 → one cycle later out_valid=1, result=0xFFFFFFFE, illegal=0.
- aluOp=10, funct7=0x01, funct3=1 (MULH), op_a=0x80000000, op_b=2 → out_valid exactly 34 edges after accept, result=0xFFFFFFFF; busy=1 and in_ready=0 meanwhile.
- DIVU op_a=100, op_b=0 → latency 1, result=0xFFFFFFFF. REM op_a=0x80000000, op_b=0xFFFFFFFF → result=0.
- aluOp=11, funct3=5, funct7=0x20 (SRAI), op_a=0xF0000000, op_b=4 → 0xFF000000. funct7=0x10 → illegal=1, result=op_a+op_b. ENABLE_M=0 with funct7=0x01 → illegal=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Then out_ready=1 with in_valid=1 (ADD 1+1) → next cycle result=2, out_valid=1, no bubble.
- Assert rst at CALC cycle 10 of a DIV → immediately out_valid=0, busy=0, result=0. After release, in_ready=1 and a fresh DIV 100/-7 → result=0xFFFFFFF2 (-14); REM 100 rem -7 → result=2.
